// File: rtl/spikehard_dma_read_unpacker.sv
// Bridges the 64-bit ESP DMA read port to the spikehard core's 32-bit word stream.
// Issues one DMA read per request and unpacks each beat into words, lower half first.
module spikehard_dma_read_unpacker #(
  parameter int DMA_BUS_WIDTH = 64,
  parameter int WORD_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_index,
  input  logic [31:0]              req_length,
  output logic                     dma_read_ctrl_valid,
  input  logic                     dma_read_ctrl_ready,
  output logic [31:0]              dma_read_ctrl_data_index,
  output logic [31:0]              dma_read_ctrl_data_length,
  output logic [2:0]               dma_read_ctrl_data_size,
  input  logic                     dma_read_chnl_valid,
  output logic                     dma_read_chnl_ready,
  input  logic [DMA_BUS_WIDTH-1:0] dma_read_chnl_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_WIDTH-1:0]    out_data,
  output logic                     out_last,
  output logic                     done
);

  localparam int R     = DMA_BUS_WIDTH / WORD_WIDTH;
  localparam int LOG2R = $clog2(R);
  localparam int SEL_W = (R > 1) ? LOG2R : 1;
  localparam logic [31:0] TAIL_MASK = 32'(R - 1);
  localparam logic [2:0]  SIZE_CODE = 3'($clog2(DMA_BUS_WIDTH / 8));

  typedef enum logic [1:0] {S_IDLE, S_CTRL, S_DATA} state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [31:0]              r_index;
  logic [31:0]              r_beats;
  logic [31:0]              r_beats_left;
  logic [31:0]              r_words_left;
  logic [DMA_BUS_WIDTH-1:0] r_buf;
  logic                     r_buf_valid;
  logic [SEL_W-1:0]         r_sel;
  logic                     r_done;

  logic [31:0]              w_req_beats;
  logic                     w_consume;
  logic                     w_last_word;
  logic                     w_buf_empty;
  logic                     w_chnl_ready;
  logic                     w_beat;
  logic [WORD_WIDTH-1:0]    w_words [R];

  // Round the word count up to whole beats; a partial tail still needs its beat.
  assign w_req_beats = (req_length >> LOG2R) + 32'(|(req_length & TAIL_MASK));

  generate
    for (genvar gi = 0; gi < R; gi++) begin : g_word
      assign w_words[gi] = r_buf[gi*WORD_WIDTH +: WORD_WIDTH];
    end
  endgenerate

  assign w_consume   = r_buf_valid & out_ready;
  assign w_last_word = (r_words_left == 32'd1);
  assign w_buf_empty = w_consume & ((r_sel == SEL_W'(R - 1)) | w_last_word);
  // Refill in the same cycle the final word of the buffer leaves, so beats stream without a bubble.
  assign w_chnl_ready = (r_state == S_DATA) & (r_beats_left != 32'd0) &
                        (~r_buf_valid | w_buf_empty);
  assign w_beat = w_chnl_ready & dma_read_chnl_valid;

  assign req_ready                 = (r_state == S_IDLE);
  assign dma_read_ctrl_valid       = (r_state == S_CTRL);
  assign dma_read_ctrl_data_index  = r_index;
  assign dma_read_ctrl_data_length = r_beats;
  assign dma_read_ctrl_data_size   = SIZE_CODE;
  assign dma_read_chnl_ready       = w_chnl_ready;
  assign out_valid                 = r_buf_valid;
  assign out_data                  = w_words[r_sel];
  assign out_last                  = r_buf_valid & w_last_word;
  assign done                      = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid && (req_length != 32'd0)) w_state_next = S_CTRL;
      S_CTRL: if (dma_read_ctrl_ready) w_state_next = S_DATA;
      S_DATA: if (w_consume && w_last_word) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_index      <= '0;
      r_beats      <= '0;
      r_beats_left <= '0;
      r_words_left <= '0;
      r_buf        <= '0;
      r_buf_valid  <= 1'b0;
      r_sel        <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_index      <= req_index;
            r_beats      <= w_req_beats;
            r_beats_left <= w_req_beats;
            r_words_left <= req_length;
            if (req_length == 32'd0) r_done <= 1'b1;
          end
        end
        S_DATA: begin
          if (w_beat) begin
            r_buf        <= dma_read_chnl_data;
            r_buf_valid  <= 1'b1;
            r_sel        <= '0;
            r_beats_left <= r_beats_left - 32'd1;
          end else if (w_buf_empty) begin
            r_buf_valid <= 1'b0;
          end else if (w_consume) begin
            r_sel <= r_sel + 1'b1;
          end
          if (w_consume) begin
            r_words_left <= r_words_left - 32'd1;
            if (w_last_word) r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spikehard_dma_read_unpacker.sv
// Directed + randomized bench for spikehard_dma_read_unpacker with a queue-based word model.
module tb_spikehard_dma_read_unpacker;

  localparam int R = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_index;
  logic [31:0] req_length;
  logic        dma_read_ctrl_valid;
  logic        dma_read_ctrl_ready;
  logic [31:0] dma_read_ctrl_data_index;
  logic [31:0] dma_read_ctrl_data_length;
  logic [2:0]  dma_read_ctrl_data_size;
  logic        dma_read_chnl_valid;
  logic        dma_read_chnl_ready;
  logic [63:0] dma_read_chnl_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        done;

  int n_checks = 0;
  int n_err    = 0;

  spikehard_dma_read_unpacker #(.DMA_BUS_WIDTH(64), .WORD_WIDTH(32)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .req_valid                 (req_valid),
    .req_ready                 (req_ready),
    .req_index                 (req_index),
    .req_length                (req_length),
    .dma_read_ctrl_valid       (dma_read_ctrl_valid),
    .dma_read_ctrl_ready       (dma_read_ctrl_ready),
    .dma_read_ctrl_data_index  (dma_read_ctrl_data_index),
    .dma_read_ctrl_data_length (dma_read_ctrl_data_length),
    .dma_read_ctrl_data_size   (dma_read_ctrl_data_size),
    .dma_read_chnl_valid       (dma_read_chnl_valid),
    .dma_read_chnl_ready       (dma_read_chnl_ready),
    .dma_read_chnl_data        (dma_read_chnl_data),
    .out_valid                 (out_valid),
    .out_ready                 (out_ready),
    .out_data                  (out_data),
    .out_last                  (out_last),
    .done                      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_req_ready"}, req_ready, 1);
    chk({pfx, "_ctrl_valid"}, dma_read_ctrl_valid, 0);
    chk({pfx, "_ctrl_index"}, dma_read_ctrl_data_index, 0);
    chk({pfx, "_ctrl_length"}, dma_read_ctrl_data_length, 0);
    chk({pfx, "_chnl_ready"}, dma_read_chnl_ready, 0);
    chk({pfx, "_out_valid"}, out_valid, 0);
    chk({pfx, "_out_data"}, out_data, 0);
    chk({pfx, "_out_last"}, out_last, 0);
    chk({pfx, "_done"}, done, 0);
  endtask

  // rmode: 0 = out_ready always high, 1 = repeating 1,0,0,1, 2 = random.
  task automatic run_req(input logic [31:0] idx, input logic [31:0] len, input int stall,
                         input int rmode, input int gap_pct, input bit tput, input bit fixed);
    logic [63:0] beats[$];
    logic [31:0] exp_w[$];
    logic [3:0]  pat;
    int nb, wi, ba, cyc;
    bit prev_beat, buf_end, exp_cr;
    pat = 4'b1001;
    nb  = (int'(len) + R - 1) / R;
    for (int b = 0; b < nb; b++) begin
      if (fixed) beats.push_back(b == 0 ? 64'h22222222_11111111 : 64'h44444444_33333333);
      else       beats.push_back({$urandom, $urandom});
    end
    foreach (beats[b]) begin
      for (int k = 0; k < R; k++)
        if (exp_w.size() < int'(len)) exp_w.push_back(beats[b][k*32 +: 32]);
    end

    req_valid  = 1'b1;
    req_index  = idx;
    req_length = len;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    next_cycle();
    req_valid  = 1'b0;
    req_index  = $urandom;
    req_length = $urandom;

    if (len == 0) begin
      @(negedge clk);
      chk("zero_done", done, 1);
      chk("zero_req_ready", req_ready, 1);
      chk("zero_ctrl_valid", dma_read_ctrl_valid, 0);
      next_cycle();
      @(negedge clk);
      chk("zero_done_clear", done, 0);
      chk("zero_ctrl_valid2", dma_read_ctrl_valid, 0);
      next_cycle();
    end else begin
      for (int s = 0; s <= stall; s++) begin
        dma_read_ctrl_ready = (s == stall);
        @(negedge clk);
        chk("ctrl_valid", dma_read_ctrl_valid, 1);
        chk("ctrl_index", dma_read_ctrl_data_index, idx);
        chk("ctrl_length", dma_read_ctrl_data_length, nb);
        chk("ctrl_size", dma_read_ctrl_data_size, 3'b011);
        chk("ctrl_no_chnl_ready", dma_read_chnl_ready, 0);
        chk("ctrl_req_ready", req_ready, 0);
        next_cycle();
      end
      dma_read_ctrl_ready = 1'b0;

      wi = 0; ba = 0; cyc = 0; prev_beat = 0;
      while (wi < int'(len) && cyc < 400) begin
        dma_read_chnl_valid = (gap_pct == 0) || ($urandom_range(99) >= gap_pct);
        dma_read_chnl_data  = (ba < nb) ? beats[ba] : {$urandom, $urandom};
        out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? pat[cyc % 4] : 1'($urandom_range(1));
        @(negedge clk);
        if (prev_beat) chk("out_valid_after_beat", out_valid, 1);
        chk("done_during_data", done, 0);
        if (out_valid) begin
          chk("out_data", out_data, exp_w[wi]);
          chk("out_last", out_last, (wi == int'(len) - 1));
        end
        buf_end = (wi % R == R - 1) || (wi == int'(len) - 1);
        exp_cr  = (ba < nb) && (!out_valid || (out_ready && buf_end));
        chk("chnl_ready", dma_read_chnl_ready, exp_cr);
        prev_beat = dma_read_chnl_valid && dma_read_chnl_ready;
        if (prev_beat) ba++;
        if (out_valid && out_ready) wi++;
        cyc++;
        next_cycle();
      end
      chk("words_consumed", wi, len);
      if (tput) chk("throughput_cycles", cyc, int'(len) + 1);
      dma_read_chnl_valid = 1'b1;
      dma_read_chnl_data  = {$urandom, $urandom};
      out_ready = 1'b1;
      @(negedge clk);
      chk("end_done", done, 1);
      chk("end_req_ready", req_ready, 1);
      chk("end_out_valid", out_valid, 0);
      chk("end_chnl_ready", dma_read_chnl_ready, 0);
      chk("beats_accepted", ba, nb);
      next_cycle();
      dma_read_chnl_valid = 1'b0;
      @(negedge clk);
      chk("end_done_clear", done, 0);
      next_cycle();
    end
    $display("req idx=%0h len=%0d stall=%0d rmode=%0d gap=%0d beats=%0d", idx, len, stall, rmode, gap_pct, nb);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_index = 0; req_length = 0;
    dma_read_ctrl_ready = 0; dma_read_chnl_valid = 0; dma_read_chnl_data = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_values("reset");
    next_cycle();
    rst = 1'b0;
    next_cycle();

    run_req(32'h10, 32'd4, 0, 0, 0, 1'b1, 1'b1);
    run_req($urandom, 32'd3, 0, 0, 0, 1'b1, 1'b0);
    run_req($urandom, 32'd0, 0, 0, 0, 1'b0, 1'b0);
    run_req($urandom, 32'd8, 0, 1, 40, 1'b0, 1'b0);
    run_req($urandom, 32'd5, 5, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++)
      run_req($urandom, 32'($urandom_range(1, 12)), $urandom_range(0, 3), 2, 30, 1'b0, 1'b0);

    req_valid = 1'b1; req_index = 32'h55; req_length = 32'd6;
    next_cycle();
    req_valid = 1'b0;
    dma_read_ctrl_ready = 1'b1;
    next_cycle();
    dma_read_ctrl_ready = 1'b0;
    dma_read_chnl_valid = 1'b1;
    dma_read_chnl_data  = {$urandom, $urandom};
    out_ready = 1'b0;
    @(negedge clk);
    chk("rst_pre_chnl_ready", dma_read_chnl_ready, 1);
    next_cycle();
    dma_read_chnl_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_out_valid", out_valid, 1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("midburst");
    $display("reset mid-burst after 1 of 3 beats");
    next_cycle();
    run_req($urandom, 32'd2, 0, 0, 0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/spikehard_dma_read_unpacker.md
# spikehard_dma_read_unpacker

- Sits between the 64-bit ESP DMA read interface and the spikehard core's 32-bit input word stream.
- Accepts one read request at a time (start index, length in 32-bit words) and issues the matching DMA read control transaction.
- Accepts 64-bit channel beats and unpacks each beat into 32-bit words, lower half first, on a valid/ready stream that marks the last word.

## Interface

Parameters:
- DMA_BUS_WIDTH, 64, DMA channel beat width; must be an integer multiple of WORD_WIDTH.
- WORD_WIDTH, 32, output word width. R = DMA_BUS_WIDTH/WORD_WIDTH words per beat; R is a power of two.

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  read request offered.
- req_ready  out  1  high only in IDLE.
- req_index  in  32  start offset, in DMA beats.
- req_length  in  32  word count, in WORD_WIDTH words.
- dma_read_ctrl_valid  out  1  control request.
- dma_read_ctrl_ready  in  1  control accept.
- dma_read_ctrl_data_index  out  32  beat index.
- dma_read_ctrl_data_length  out  32  beat count.
- dma_read_ctrl_data_size  out  3  3'b011 (64-bit) for DMA_BUS_WIDTH=64; 3'b010 for 32.
- dma_read_chnl_valid  in  1  beat available.
- dma_read_chnl_ready  out  1  beat accept.
- dma_read_chnl_data  in  DMA_BUS_WIDTH  beat data.
- out_valid  out  1  word available.
- out_ready  in  1  consumer accept.
- out_data  out  WORD_WIDTH  unpacked word.
- out_last  out  1  qualifies the final word of the request.
- done  out  1  one-cycle pulse at request completion.

## Operation

FSM states: IDLE, CTRL, DATA.

- **IDLE**
  - req_ready=1.
  - On req_valid, latch index and length. Compute beats = (length >> log2 R) + (|length[log2R-1:0]), in 32 bits; this cannot overflow.
  - If length==0: pulse done next cycle, stay in IDLE, issue no DMA transaction.
  - Otherwise go to CTRL.
- **CTRL**
  - dma_read_ctrl_valid=1 with the latched index/beats/size.
  - All ctrl outputs stay stable until dma_read_ctrl_ready.
  - On the handshake go to DATA.
- **DATA**
  - One-beat holding buffer, a word selector sel (0..R-1), beats_left and words_left counters.
  - out_data = buf[sel*WORD_WIDTH +: WORD_WIDTH]; out_valid = buf_valid.
  - A word is consumed on out_valid & out_ready: sel increments and words_left decrements.
  - The buffer empties when sel==R-1 or words_left==1 is consumed.
  - dma_read_chnl_ready = (beats_left!=0) & (!buf_valid | buffer-emptying consume this cycle). This bypass gives full throughput: one word per cycle, no bubble between beats.
  - On a beat handshake: load buf, buf_valid=1, sel=0, beats_left-1.
  - out_last = out_valid & (words_left==1).
  - On consuming the last word: done pulses in the same cycle as that handshake is registered (next cycle high for one cycle), state returns to IDLE.
- **Odd tail:** when length is not a multiple of R, the unused upper words of the final beat are discarded and never presented.
- **Extra beats:** channel beats offered while beats_left==0 are not accepted (chnl_ready=0).
- **rst:** returns to IDLE regardless of state. Any outstanding DMA transaction is abandoned; the system reset clears the DMA engine too.

## Timing

- Reset values: req_ready=1 (IDLE), dma_read_ctrl_valid=0, ctrl data outputs=0, dma_read_chnl_ready=0, out_valid=0, out_data=0, out_last=0, done=0.
- Request accept at cycle T gives dma_read_ctrl_valid at T+1.
- Ctrl handshake at cycle C makes dma_read_chnl_ready high from C+1.
- Beat accepted at cycle B makes out_valid high at B+1 with the lower word.
- With out_ready held high and back-to-back beats: R words per R cycles sustained.
- Last word consumed at cycle L: done=1 and req_ready=1 at L+1. A new request can be accepted at L+1.
- out_data/out_valid/out_last hold stable while out_valid & !out_ready.
- Zero-length request accepted at T: done=1 at T+1, req_ready stays 1.

## Test plan

- **Basic request:** req index=0x10, length=4; ctrl_ready=1; beats 0x22222222_11111111 then 0x44444444_33333333 -> ctrl index=0x10, length=2, size=3'b011; words 0x11111111, 0x22222222, 0x33333333, 0x44444444(last); done once.
- **Odd length:** length=3 -> ctrl length=2; three words out, the upper word of beat 2 is never presented; out_last on the third word.
- **Zero length:** length=0 -> no dma_read_ctrl_valid; done pulses at T+1; req_ready stays 1.
- **Backpressure:** length=8 with out_ready toggling 1,0,0,1 and dma_read_chnl_valid with random gaps -> word order exact; chnl_ready never high with a full unconsumed buffer; exactly 4 beats accepted.
- **Control stall:** dma_read_ctrl_ready held low 5 cycles -> ctrl valid/index/length held stable; no chnl_ready before the handshake.
- **Reset mid-burst:** rst asserted after 1 of 3 beats -> next cycle all outputs at reset values; a fresh length=2 request then completes normally.
